// File: rtl/gerenciador_chamadas.sv
// gerenciador_chamadas: request latch, SCAN target selection and door sequencing for
// controle_andares.
//
// Ports:
//   clock_in           system clock, rising edge
//   reset              synchronous, active-high
//   botoes[3:0]        level-sensitive call buttons, bit i = floor i
//   andar[1:0]         current floor reported by controle_andares
//   seletor_andar[1:0] target floor handed to controle_andares
//   pessoa_para_descer high while the door is open
//   porta_fechada      high only while the door is fully closed
//   pedidos[3:0]       pending-request register
//   direcao            1 = up, 0 = down
//   estado[1:0]        0 PARADO, 1 MOVENDO, 2 ABERTA, 3 FECHANDO
module gerenciador_chamadas #(
  parameter int unsigned TEMPO_PORTA  = 4,
  parameter int unsigned TEMPO_FECHAR = 2,
  parameter int unsigned LARG_TEMP    = 3
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic [3:0] botoes,
  input  logic [1:0] andar,
  output logic [1:0] seletor_andar,
  output logic       pessoa_para_descer,
  output logic       porta_fechada,
  output logic [3:0] pedidos,
  output logic       direcao,
  output logic [1:0] estado
);

  typedef enum logic [1:0] {
    StParado   = 2'd0,
    StMovendo  = 2'd1,
    StAberta   = 2'd2,
    StFechando = 2'd3
  } estado_t;

  localparam logic [LARG_TEMP-1:0] CargaPorta  = LARG_TEMP'(TEMPO_PORTA - 1);
  localparam logic [LARG_TEMP-1:0] CargaFechar = LARG_TEMP'(TEMPO_FECHAR - 1);

  estado_t              r_estado;
  logic [1:0]           r_sel;
  logic [3:0]           r_ped;
  logic                 r_dir;
  logic                 r_porta;
  logic                 r_pessoa;
  logic [LARG_TEMP-1:0] r_timer;

  estado_t              w_estado_prox;
  logic [1:0]           w_sel_prox;
  logic [3:0]           w_ped_prox;
  logic                 w_dir_prox;
  logic [LARG_TEMP-1:0] w_timer_prox;

  logic                 w_cima_ok;
  logic [1:0]           w_cima;
  logic                 w_baixo_ok;
  logic [1:0]           w_baixo;
  logic [3:0]           w_mascara;
  logic                 w_porta_aberta;
  logic                 w_entra_aberta;

  // Nearest pending floor strictly above and strictly below the current floor.
  always_comb begin
    w_cima_ok  = 1'b0;
    w_cima     = 2'd0;
    w_baixo_ok = 1'b0;
    w_baixo    = 2'd0;
    // Scanning downwards leaves the lowest floor above andar.
    for (int i = 3; i >= 0; i--) begin
      if ((2'(i) > andar) && r_ped[i]) begin
        w_cima_ok = 1'b1;
        w_cima    = 2'(i);
      end
    end
    // Scanning upwards leaves the highest floor below andar.
    for (int i = 0; i < 4; i++) begin
      if ((2'(i) < andar) && r_ped[i]) begin
        w_baixo_ok = 1'b1;
        w_baixo    = 2'(i);
      end
    end
  end

  always_comb begin
    w_estado_prox = r_estado;
    w_sel_prox    = r_sel;
    w_dir_prox    = r_dir;
    w_timer_prox  = r_timer;

    case (r_estado)
      StParado: begin
        w_sel_prox   = andar;
        w_timer_prox = '0;
        if (r_ped[andar]) begin
          w_estado_prox = StAberta;
          w_timer_prox  = CargaPorta;
        end else if (r_ped != 4'b0000) begin
          w_estado_prox = StMovendo;
          // Keep direction while something lies ahead, otherwise reverse.
          if ((r_dir && w_cima_ok) || (!r_dir && !w_baixo_ok)) begin
            w_sel_prox = w_cima;
            w_dir_prox = 1'b1;
          end else begin
            w_sel_prox = w_baixo;
            w_dir_prox = 1'b0;
          end
        end
      end
      StMovendo: begin
        if (andar == r_sel) begin
          w_estado_prox = StAberta;
          w_timer_prox  = CargaPorta;
        end else if (r_dir && w_cima_ok && (w_cima < r_sel)) begin
          w_sel_prox = w_cima;
        end else if (!r_dir && w_baixo_ok && (w_baixo > r_sel)) begin
          w_sel_prox = w_baixo;
        end
      end
      StAberta: begin
        if (botoes[andar]) begin
          w_timer_prox = CargaPorta;
        end else if (r_timer == '0) begin
          w_estado_prox = StFechando;
          w_timer_prox  = CargaFechar;
        end else begin
          w_timer_prox = r_timer - 1'b1;
        end
      end
      StFechando: begin
        if (botoes[andar]) begin
          w_estado_prox = StAberta;
          w_timer_prox  = CargaPorta;
        end else if (r_timer == '0) begin
          w_estado_prox = StParado;
          w_timer_prox  = '0;
        end else begin
          w_timer_prox = r_timer - 1'b1;
        end
      end
      default: begin
        w_estado_prox = StParado;
      end
    endcase
  end

  // Request latching: the current floor's button is ignored while the door is open or
  // closing, and the current floor is cleared on entry to ABERTA (clear beats set).
  always_comb begin
    w_mascara      = 4'b0001 << andar;
    w_porta_aberta = (r_estado == StAberta) || (r_estado == StFechando);
    w_entra_aberta = (w_estado_prox == StAberta) && (r_estado != StAberta);
    w_ped_prox     = r_ped | botoes;
    if (w_porta_aberta) begin
      w_ped_prox = r_ped | (botoes & ~w_mascara);
    end
    if (w_entra_aberta) begin
      w_ped_prox = w_ped_prox & ~w_mascara;
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_estado <= StParado;
      r_sel    <= 2'd0;
      r_ped    <= 4'b0000;
      r_dir    <= 1'b1;
      r_porta  <= 1'b1;
      r_pessoa <= 1'b0;
      r_timer  <= '0;
    end else begin
      r_estado <= w_estado_prox;
      r_sel    <= w_sel_prox;
      r_ped    <= w_ped_prox;
      r_dir    <= w_dir_prox;
      r_timer  <= w_timer_prox;
      // Door flags are registered from the next state so they line up with estado.
      r_porta  <= (w_estado_prox == StParado) || (w_estado_prox == StMovendo);
      r_pessoa <= (w_estado_prox == StAberta);
    end
  end

  assign seletor_andar      = r_sel;
  assign pessoa_para_descer = r_pessoa;
  assign porta_fechada      = r_porta;
  assign pedidos            = r_ped;
  assign direcao            = r_dir;
  assign estado             = r_estado;

endmodule

// File: tb/tb_gerenciador_chamadas.sv
module tb_gerenciador_chamadas;

  localparam logic [1:0] P = 2'd0;
  localparam logic [1:0] M = 2'd1;
  localparam logic [1:0] A = 2'd2;
  localparam logic [1:0] F = 2'd3;

  typedef struct packed {
    logic [1:0] est;
    logic [1:0] sel;
    logic [3:0] ped;
    logic       dir;
    logic       pf;
    logic       pp;
  } exp_t;

  typedef struct {
    string      nome;
    logic       rst;
    logic [3:0] b;
    logic [1:0] a;
    exp_t       e;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] botoes = 4'b0000;
  logic [1:0] andar = 2'd0;
  logic [1:0] seletor_andar;
  logic       pessoa_para_descer;
  logic       porta_fechada;
  logic [3:0] pedidos;
  logic       direcao;
  logic [1:0] estado;

  int checks = 0;
  int failures = 0;

  vec_t  tabela[$];
  exp_t  sb[$];
  string sb_nome[$];

  gerenciador_chamadas #(
    .TEMPO_PORTA (4),
    .TEMPO_FECHAR(2),
    .LARG_TEMP   (3)
  ) dut (
    .clock_in          (clk),
    .reset             (reset),
    .botoes            (botoes),
    .andar             (andar),
    .seletor_andar     (seletor_andar),
    .pessoa_para_descer(pessoa_para_descer),
    .porta_fechada     (porta_fechada),
    .pedidos           (pedidos),
    .direcao           (direcao),
    .estado            (estado)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(logic [1:0] est, logic [1:0] sel, logic [3:0] ped, logic dir,
                              logic pf, logic pp);
    exp_t e;
    e.est = est;
    e.sel = sel;
    e.ped = ped;
    e.dir = dir;
    e.pf  = pf;
    e.pp  = pp;
    return e;
  endfunction

  function automatic void add(string nome, logic rst, logic [3:0] b, logic [1:0] a, exp_t e,
                              int n);
    vec_t v;
    v.nome = nome;
    v.rst  = rst;
    v.b    = b;
    v.a    = a;
    v.e    = e;
    for (int k = 0; k < n; k++) tabela.push_back(v);
  endfunction

  task automatic comparar();
    exp_t  e;
    exp_t  got;
    string nome;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty: no expected record queued");
    end else begin
      e    = sb.pop_front();
      nome = sb_nome.pop_front();
      got  = mk(estado, seletor_andar, pedidos, direcao, porta_fechada, pessoa_para_descer);
      if (got !== e) begin
        failures++;
        $display("FAIL %s: got estado=%0d sel=%0d ped=%b dir=%b pf=%b pp=%b, need estado=%0d sel=%0d ped=%b dir=%b pf=%b pp=%b",
                 nome, got.est, got.sel, got.ped, got.dir, got.pf, got.pp,
                 e.est, e.sel, e.ped, e.dir, e.pf, e.pp);
      end
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, then check them.
  task automatic passo(string nome, logic rst, logic [3:0] b, logic [1:0] a, exp_t e);
    reset  = rst;
    botoes = b;
    andar  = a;
    sb.push_back(e);
    sb_nome.push_back(nome);
    @(posedge clk);
    #1;
    comparar();
  endtask

  initial begin
    // Reset and idle.
    add("reset",     1, 4'h0, 0, mk(P, 0, 4'h0, 1, 1, 0), 2);
    add("idle",      0, 4'h0, 0, mk(P, 0, 4'h0, 1, 1, 0), 10);
    // Call to floor 3 from floor 0, collision of set and clear on arrival.
    add("latch3",    0, 4'h8, 0, mk(P, 0, 4'h8, 1, 1, 0), 1);
    add("move3",     0, 4'h0, 0, mk(M, 3, 4'h8, 1, 1, 0), 1);
    add("arrive3",   0, 4'h8, 3, mk(A, 3, 4'h0, 1, 0, 1), 1);
    add("open3",     0, 4'h0, 3, mk(A, 3, 4'h0, 1, 0, 1), 3);
    add("close3",    0, 4'h0, 3, mk(F, 3, 4'h0, 1, 0, 0), 2);
    add("stop3",     0, 4'h0, 3, mk(P, 3, 4'h0, 1, 1, 0), 1);
    // Retarget to floor 2 while travelling 0 -> 3, then serve 3 going up.
    add("back0",     0, 4'h0, 0, mk(P, 0, 4'h0, 1, 1, 0), 1);
    add("latch3b",   0, 4'h8, 0, mk(P, 0, 4'h8, 1, 1, 0), 1);
    add("move3b",    0, 4'h0, 0, mk(M, 3, 4'h8, 1, 1, 0), 1);
    add("floor1",    0, 4'h0, 1, mk(M, 3, 4'h8, 1, 1, 0), 1);
    add("latch2",    0, 4'h4, 1, mk(M, 3, 4'hC, 1, 1, 0), 1);
    add("retarget2", 0, 4'h0, 1, mk(M, 2, 4'hC, 1, 1, 0), 1);
    add("arrive2",   0, 4'h0, 2, mk(A, 2, 4'h8, 1, 0, 1), 1);
    add("open2",     0, 4'h0, 2, mk(A, 2, 4'h8, 1, 0, 1), 3);
    add("close2",    0, 4'h0, 2, mk(F, 2, 4'h8, 1, 0, 0), 2);
    add("stop2",     0, 4'h0, 2, mk(P, 2, 4'h8, 1, 1, 0), 1);
    add("move3c",    0, 4'h0, 2, mk(M, 3, 4'h8, 1, 1, 0), 1);
    add("arrive3c",  0, 4'h0, 3, mk(A, 3, 4'h0, 1, 0, 1), 1);
    add("open3c",    0, 4'h0, 3, mk(A, 3, 4'h0, 1, 0, 1), 3);
    add("close3c",   0, 4'h0, 3, mk(F, 3, 4'h0, 1, 0, 0), 2);
    add("stop3c",    0, 4'h0, 3, mk(P, 3, 4'h0, 1, 1, 0), 1);
    // Direction reversal from floor 2 going up with only floor 0 pending.
    add("at2",       0, 4'h0, 2, mk(P, 2, 4'h0, 1, 1, 0), 1);
    add("latch0",    0, 4'h1, 2, mk(P, 2, 4'h1, 1, 1, 0), 1);
    add("reverse",   0, 4'h0, 2, mk(M, 0, 4'h1, 0, 1, 0), 1);
    add("arrive0",   0, 4'h0, 0, mk(A, 0, 4'h0, 0, 0, 1), 1);
    add("open0",     0, 4'h0, 0, mk(A, 0, 4'h0, 0, 0, 1), 2);

    reset = 1'b1;
    #1;
    foreach (tabela[i]) passo(tabela[i].nome, tabela[i].rst, tabela[i].b, tabela[i].a,
                              tabela[i].e);

    // Re-press at timer=1 in ABERTA, then again during FECHANDO; the button never latches.
    passo("repress_open", 0, 4'h1, 0, mk(A, 0, 4'h0, 0, 0, 1));
    for (int k = 0; k < 3; k++) passo("extended", 0, 4'h0, 0, mk(A, 0, 4'h0, 0, 0, 1));
    passo("closing0", 0, 4'h0, 0, mk(F, 0, 4'h0, 0, 0, 0));
    passo("repress_close", 0, 4'h1, 0, mk(A, 0, 4'h0, 0, 0, 1));
    for (int k = 0; k < 3; k++) passo("reopened", 0, 4'h0, 0, mk(A, 0, 4'h0, 0, 0, 1));
    for (int k = 0; k < 2; k++) passo("closing0b", 0, 4'h0, 0, mk(F, 0, 4'h0, 0, 0, 0));
    passo("stop0", 0, 4'h0, 0, mk(P, 0, 4'h0, 0, 1, 0));

    // Two floors latched together; floor 0 going down reverses; reset mid-move.
    passo("latch_multi", 0, 4'h6, 0, mk(P, 0, 4'h6, 0, 1, 0));
    passo("reverse0", 0, 4'h0, 0, mk(M, 1, 4'h6, 1, 1, 0));
    passo("reset_moving", 1, 4'h0, 0, mk(P, 0, 4'h0, 1, 1, 0));
    for (int k = 0; k < 2; k++) passo("after_reset", 0, 4'h0, 0, mk(P, 0, 4'h0, 1, 1, 0));

    // Floor 3 going up reverses downwards; a second reset restores direcao=1.
    passo("at3", 0, 4'h0, 3, mk(P, 3, 4'h0, 1, 1, 0));
    passo("latch2_top", 0, 4'h4, 3, mk(P, 3, 4'h4, 1, 1, 0));
    passo("reverse3", 0, 4'h0, 3, mk(M, 2, 4'h4, 0, 1, 0));
    passo("reset_down", 1, 4'h0, 3, mk(P, 0, 4'h0, 1, 1, 0));

    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover: %0d records left, need 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gerenciador_chamadas.md
Name: gerenciador_chamadas

Overview:
Upstream request and door stage for controle_andares. It latches the floor call buttons and picks the next target floor with a SCAN policy (keep the current direction while requests lie ahead). It drives seletor_andar, which controle_andares compares against its floor, and it sequences the door through pessoa_para_descer and porta_fechada. The current-floor output andar of controle_andares feeds back into this block.

Parameters:
TEMPO_PORTA, 4, cycles the door stays open (ABERTA), must be >=1
TEMPO_FECHAR, 2, cycles of the closing phase (FECHANDO), must be >=1
LARG_TEMP, 3, timer width, must satisfy 2^LARG_TEMP > max(TEMPO_PORTA, TEMPO_FECHAR)

Ports:
clock_in  input  1  single system clock, all state updates on rising edge
reset  input  1  synchronous, active-high
botoes  input  4  call buttons for floors 0..3, level-sensitive, bit i = floor i
andar  input  2  current floor, from controle_andares.andar
seletor_andar  output  2  target floor, to controle_andares.seletor_andar
pessoa_para_descer  output  1  high while the door is open, to controle_andares
porta_fechada  output  1  high only when the door is fully closed
pedidos  output  4  pending-request register
direcao  output  1  1 = up, 0 = down
estado  output  2  FSM state: 0 PARADO, 1 MOVENDO, 2 ABERTA, 3 FECHANDO

Behaviour:
- Reset (sync, priority over everything) sets: estado=PARADO, pedidos=0, direcao=1, seletor_andar=0, pessoa_para_descer=0, porta_fechada=1, timer=0. Reset mid-operation drops all pending requests.
- All outputs are registered.
- Latching: pedidos[i] <= pedidos[i] | botoes[i] every cycle, except the clear rules below. Latency is 1 cycle from button to pedidos.
- Clear: the bit for the current floor (andar) is cleared on the same edge the FSM enters ABERTA. When set and clear collide on the same bit, clear wins.
- Pressing the current floor's button while in ABERTA or FECHANDO never latches. It re-opens the door instead (see below).
- Target function alvo(dir), combinational over pedidos and andar:
  - Nearest pending floor strictly ahead of andar in dir.
  - If none, nearest pending floor strictly ahead in the opposite direction, and direcao flips.
- PARADO: porta_fechada=1, pessoa_para_descer=0, seletor_andar=andar (so G=L=0 and there is no motion).
  - If pedidos[andar]: go to ABERTA.
  - Else if pedidos != 0: seletor_andar <= alvo, update direcao, go to MOVENDO.
  - Else stay.
- MOVENDO: porta_fechada=1, pessoa_para_descer=0.
  - If andar == seletor_andar: go to ABERTA, clear pedidos[andar], direcao unchanged.
  - Else if a pending floor lies strictly ahead in direcao and strictly nearer than seletor_andar: retarget seletor_andar to it. Retargeting never changes direction.
- ABERTA: porta_fechada=0, pessoa_para_descer=1.
  - On entry the timer loads TEMPO_PORTA-1 and decrements each cycle.
  - At timer==0: go to FECHANDO, load TEMPO_FECHAR-1.
  - botoes[andar]=1 reloads TEMPO_PORTA-1.
- FECHANDO: porta_fechada=0, pessoa_para_descer=0.
  - botoes[andar]=1 returns to ABERTA and reloads TEMPO_PORTA-1.
  - At timer==0: go to PARADO. porta_fechada rises on that edge.
- Total stop time with no re-press: exactly TEMPO_PORTA + TEMPO_FECHAR cycles with porta_fechada=0.
- Boundaries:
  - Floor 3 has nothing ahead going up, and floor 0 has nothing ahead going down. In both cases alvo reverses.
  - Requests at several floors in the same cycle are all latched.
  - seletor_andar never changes during ABERTA or FECHANDO.

Test Plan:
- Reset then idle, botoes=0, andar=0 -> estado=0, porta_fechada=1, seletor_andar=0, pedidos=0, direcao=1 for 10 cycles.
- andar=0, pulse botoes=4'b1000 for 1 cycle -> pedidos=1000 next cycle. The following cycle estado=MOVENDO, seletor_andar=3. With andar forced to 3, ABERTA is entered and pedidos=0000. pessoa_para_descer=1 for 4 cycles, then porta_fechada=0 for 2 cycles, then back to PARADO.
- During MOVENDO 0->3 with andar=1, pulse botoes[2] -> seletor_andar retargets to 2 and stops at 2. pedidos[3] stays set, then floor 3 is served without a direction change.
- At andar=2, direcao=1, pedidos=0001 -> direcao flips to 0, seletor_andar=0.
- In ABERTA at timer=1, press the current floor button -> the open phase extends to 4 further cycles. In FECHANDO, press again -> back to ABERTA, porta_fechada stays 0 throughout.
- Assert reset during MOVENDO with pedidos=0110 -> the next cycle matches all reset values and pedidos=0.
